mux41_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 data multiplexer among four requesters.

---
 rtl/mux41_rr_arbiter_pkg.sv | 28 ++
 rtl/mux41_rr_arbiter_rr_pick4.sv | 31 +++
 rtl/mux41_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux41_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared definitions for the 4-input round-robin mux arbiter.
//   N_REQ / SEL_W : requester count and mux-select width
//   arb_state_e   : two-state controller encoding (IDLE / GRANT)
//   arb_dbg_t     : observation bundle exporting FSM state and rotation pointer
//   onehot4       : index -> one-hot grant vector helper
package mux41_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e       state;
        logic [SEL_W-1:0] ptr;
    } arb_dbg_t;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
//   req   [3:0] : request vector
//   ptr   [1:0] : highest-priority index; scan order is ptr, ptr+1, .. mod 4
//   idx   [1:0] : index of the first set request in scan order (ptr when none)
//   found       : 1 when any request bit is set
module rr_pick4
    import mux41_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            // Candidate index wraps naturally in SEL_W bits.
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// mux41_rr_arbiter: round-robin arbiter owning the select of a shared 4:1 mux.
//   clk       : clock, all state on rising edge
//   clr       : synchronous active-high reset, overrides all other inputs
//   req  [3:0]: per-source request
//   gnt  [3:0]: registered one-hot grant, zero when idle
//   sel  [1:0]: registered mux select; holds its last value while idle
//   busy      : registered, equals |gnt
//   hold_cnt  : registered count of cycles the current grant has been held
//   dbg_o     : FSM state and rotation pointer for observation
// A holder is forced off after MAX_HOLD grant cycles only when someone else
// is waiting; every grant change passes through one all-zero IDLE cycle.
module mux41_rr_arbiter
    import mux41_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
)(
    input  logic             clk,
    input  logic             clr,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [CW-1:0]    hold_cnt,
    output arb_dbg_t         dbg_o
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             busy_q,  busy_d;
    logic [CW-1:0]    hold_q,  hold_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             holder_req;
    logic             others_wait;
    logic             at_limit;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign holder_req  = req[sel_q];
    // gnt_q is one-hot at sel_q during GRANT, so this masks out the holder.
    assign others_wait = |(req & ~gnt_q);
    assign at_limit    = (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot4(pick_idx);
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                // Release and preempt share one path; the holder is re-queued
                // behind everyone else by moving ptr past it.
                if (!holder_req || (at_limit && others_wait)) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end else if (at_limit) begin
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign hold_cnt    = hold_q;
    assign dbg_o.state = state_q;
    assign dbg_o.ptr   = ptr_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter (MAX_HOLD = 4).
module tb_mux41_rr_arbiter;
    import mux41_rr_arbiter_pkg::*;

    localparam int MH = 4;
    localparam int CW = 8;
    localparam int W  = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           clr;
    logic [3:0]     req;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic           busy;
    logic [CW-1:0]  hold_cnt;
    arb_dbg_t       dbg_o;

    mux41_rr_arbiter #(.MAX_HOLD(MH), .CW(CW)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .hold_cnt (hold_cnt),
        .dbg_o    (dbg_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // owner = -1 means nobody holds the mux.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;

    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] model_vec();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g = 4'(1 << m_owner);
        return {g, 2'(m_sel), (m_owner >= 0), 8'(m_hold), 2'(m_ptr), (m_owner >= 0)};
    endfunction

    task automatic model_update(input logic [3:0] r, input logic c);
        int others;
        if (c) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                if (m_owner < 0 && r[(m_ptr + i) % 4]) begin
                    m_owner = (m_ptr + i) % 4;
                    m_sel   = m_owner;
                    m_hold  = 0;
                end
            end
        end else begin
            others = int'(r) & ~(1 << m_owner);
            if (!r[m_owner] || (m_hold == MH - 1 && others != 0)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold = (m_hold + 1) % MH;
            end
        end
    endtask

    logic [W-1:0] obs;
    assign obs = {gnt, sel, busy, hold_cnt, dbg_o.ptr, logic'(dbg_o.state)};

    // ---------------- driver ----------------
    task automatic step(input logic [3:0] r, input logic c);
        req = r;
        clr = c;
        @(posedge clk);
        model_update(r, c);
        exp_q.push_back(model_vec());
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        for (int i = 0; i < 2; i++) begin
            step(4'b1111, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs, e);
            end
            n_cmp++;
            if ({gnt, sel, busy, hold_cnt} !== 15'd0) begin
                n_bad++;
                $display("FAIL reset_zero cyc%0d: gnt=%b sel=%0d busy=%b hold=%0d want all 0",
                         i, gnt, sel, busy, hold_cnt);
            end
        end
    endtask

    task automatic test_single();
        logic [W-1:0] e;
        step(4'b0000, 1'b1); void'(exp_q.pop_front());
        step(4'b0100, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || obs !== e) begin
            n_bad++;
            $display("FAIL single_grant: got gnt=%b sel=%0d busy=%b want 0100/2/1", gnt, sel, busy);
        end
        step(4'b0000, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0000 || sel !== 2'd2 || busy !== 1'b0 || obs !== e) begin
            n_bad++;
            $display("FAIL single_release: got gnt=%b sel=%0d busy=%b want 0000/2/0", gnt, sel, busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        logic [W-1:0] e;
        step(4'b0000, 1'b1); void'(exp_q.pop_front());
        // Grants of MH cycles separated by a single idle cycle, rotating 0,1,2,3,0.
        for (int n = 0; n < 5 * 5 - 1; n++) begin
            step(4'b1111, 1'b0);
            e = exp_q.pop_front();
            eg = (n % 5 == 4) ? 4'b0000 : 4'(1 << ((n / 5) % 4));
            n_cmp++;
            if (gnt !== eg || obs !== e) begin
                n_bad++;
                $display("FAIL fairness cyc%0d: got gnt=%b obs=%h want gnt=%b obs=%h", n, gnt, obs, eg, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] e;
        step(4'b0000, 1'b1); void'(exp_q.pop_front());
        step(4'b1010, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0010 || obs !== e) begin
            n_bad++;
            $display("FAIL simul_first: got gnt=%b want 0010", gnt);
        end
        step(4'b1000, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0000 || sel !== 2'd1 || obs !== e) begin
            n_bad++;
            $display("FAIL simul_gap: got gnt=%b sel=%0d want 0000/1", gnt, sel);
        end
        step(4'b1000, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || obs !== e) begin
            n_bad++;
            $display("FAIL simul_second: got gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
    endtask

    task automatic test_lone_holder();
        logic [W-1:0] e;
        step(4'b0000, 1'b1); void'(exp_q.pop_front());
        for (int n = 0; n < 20; n++) begin
            step(4'b0001, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== 4'b0001 || hold_cnt !== CW'(n % MH) || obs !== e) begin
                n_bad++;
                $display("FAIL lone cyc%0d: got gnt=%b hold=%0d want 0001/%0d", n, gnt, hold_cnt, n % MH);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [W-1:0] e;
        step(4'b0000, 1'b1); void'(exp_q.pop_front());
        for (int n = 0; n < 3; n++) begin
            step(4'b1111, 1'b0); void'(exp_q.pop_front());
        end
        n_cmp++;
        if (hold_cnt !== CW'(2) || gnt !== 4'b0001) begin
            n_bad++;
            $display("FAIL midclr_setup: got hold=%0d gnt=%b want 2/0001", hold_cnt, gnt);
        end
        step(4'b1111, 1'b1);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0000 || dbg_o.ptr !== 2'd0 || busy !== 1'b0 || obs !== e) begin
            n_bad++;
            $display("FAIL midclr_reset: got gnt=%b ptr=%0d busy=%b want 0000/0/0", gnt, dbg_o.ptr, busy);
        end
        step(4'b1111, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (gnt !== 4'b0001 || obs !== e) begin
            n_bad++;
            $display("FAIL midclr_regrant: got gnt=%b want 0001", gnt);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [3:0]   rq;
        logic         c;
        rq = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 39) == 0);
            step(rq, c);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL random cyc%0d req=%b clr=%b: got %h want %h", n, rq, c, obs, e);
            end
            n_cmp++;
            if ($countones(gnt) > 1 || busy !== (|gnt) || (gnt != 4'b0 && !gnt[sel])) begin
                n_bad++;
                $display("FAIL invariant cyc%0d: gnt=%b sel=%0d busy=%b", n, gnt, sel, busy);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clr = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_fairness();
        test_simultaneous();
        test_lone_holder();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
